// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-issue stage: instruction classes,
// instruction field positions, the hard-wired zero register and ALU fn codes.
package alu_pkg;

    // Instruction class, taken from the top two bits of the instruction word
    typedef enum logic [1:0] {
        CLASS_NOP = 2'b00,
        CLASS_ILL = 2'b01,
        CLASS_RR  = 2'b10,
        CLASS_RL  = 2'b11
    } class_e;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Register index that always reads 0 and is never pending
    localparam int ZERO_REG = 31;

    // Instruction field bit positions
    localparam int CLASS_HI = 31;
    localparam int CLASS_LO = 30;
    localparam int FN_HI    = 29;
    localparam int FN_LO    = 24;
    localparam int RC_HI    = 23;
    localparam int RC_LO    = 19;
    localparam int RA_HI    = 18;
    localparam int RA_LO    = 14;
    localparam int RB_HI    = 13;
    localparam int RB_LO    = 9;
    localparam int LIT_HI   = 13;
    localparam int LIT_LO   = 0;
    localparam int LIT_W    = LIT_HI - LIT_LO + 1;

    // ALU fn encoding: fn[5:4] selects the unit, fn[0] selects subtract
    localparam logic [1:0] FN_UNIT_CMP   = 2'b00;
    localparam logic [1:0] FN_UNIT_ARITH = 2'b01;
    localparam logic [1:0] FN_UNIT_BOOL  = 2'b10;
    localparam logic [1:0] FN_UNIT_SHIFT = 2'b11;
    localparam logic [5:0] FN_ADD        = 6'b010000;
    localparam logic [5:0] FN_SUB        = 6'b010001;

    // Class field of an instruction word
    function automatic logic [1:0] instr_class(input logic [31:0] instr);
        return instr[CLASS_HI:CLASS_LO];
    endfunction

endpackage

// File: rtl/alu_issue_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register.
// A bit is set when an instruction writing that register issues and cleared
// by its writeback; a simultaneous set and clear of one register leaves it set.
// Flush and reset clear every bit. The zero register is never marked pending.
module alu_issue_scoreboard
    import alu_pkg::*;
#(
    parameter int ZERO_IDX = ZERO_REG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_flush,
    input  logic       i_set_en,
    input  logic [4:0] i_set_rc,
    input  logic       i_clr_en,
    input  logic [4:0] i_clr_rc,
    input  logic [4:0] i_ra,
    input  logic [4:0] i_rb,
    input  logic [4:0] i_rc,
    output logic       o_pend_ra,
    output logic       o_pend_rb,
    output logic       o_pend_rc
);

    localparam logic [4:0] L_ZERO = 5'(ZERO_IDX);

    logic [31:0] r_pend;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;

    // Decode the set and clear requests into one-hot masks
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en && (i_set_rc != L_ZERO)) begin
            w_set_mask[i_set_rc] = 1'b1;
        end
        if (i_clr_en) begin
            w_clr_mask[i_clr_rc] = 1'b1;
        end
    end

    // Pending bits: clear first, then set, so a set wins over a clear
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_pend_ra = r_pend[i_ra];
    assign o_pend_rb = r_pend[i_rb];
    assign o_pend_rc = r_pend[i_rc];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage in front of the ALU. Decodes one instruction per cycle,
// reads the register file, resolves the literal, stalls on scoreboard hazards
// and holds the issued operands in a one-entry output register.
// Optional feature: define ALU_ISSUE_FORWARD_EN to bypass writeback data onto
// source operands in the writeback cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never depends on ready. in_ready is derived from in_instr and
// the scoreboard (plus out_ready for the output slot), never from ALU results.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ZERO_REG = alu_pkg::ZERO_REG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic [4:0]      ra_addr,
    output logic [4:0]      rb_addr,
    input  logic [XLEN-1:0] ra_data,
    input  logic [XLEN-1:0] rb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [5:0]      out_fn,
    output logic [4:0]      out_rc,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rc,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            illegal,
    output logic            dbg_state
);

    localparam logic [4:0] L_ZERO = 5'(ZERO_REG);

    out_state_e       r_state;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [5:0]       r_fn;
    logic [4:0]       r_rc;
    logic             r_illegal;

    logic [1:0]       w_class;
    logic [5:0]       w_fn;
    logic [4:0]       w_rc;
    logic [4:0]       w_ra;
    logic [4:0]       w_rb;
    logic [LIT_W-1:0] w_lit;
    logic             w_pend_ra;
    logic             w_pend_rb;
    logic             w_pend_rc;
    logic             w_fwd_ra;
    logic             w_fwd_rb;
    logic [XLEN-1:0]  w_ra_val;
    logic [XLEN-1:0]  w_rb_val;
    logic             w_hazard;
    logic             w_accept;
    logic             w_issue;
    logic [XLEN-1:0]  w_a;
    logic [XLEN-1:0]  w_b;

    assign w_class = instr_class(in_instr);
    assign w_fn    = in_instr[FN_HI:FN_LO];
    assign w_rc    = in_instr[RC_HI:RC_LO];
    assign w_ra    = in_instr[RA_HI:RA_LO];
    assign w_rb    = in_instr[RB_HI:RB_LO];
    assign w_lit   = in_instr[LIT_HI:LIT_LO];

    assign ra_addr = w_ra;
    assign rb_addr = w_rb;

    alu_issue_scoreboard #(
        .ZERO_IDX (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .i_flush   (flush),
        .i_set_en  (w_issue),
        .i_set_rc  (w_rc),
        .i_clr_en  (wb_valid),
        .i_clr_rc  (wb_rc),
        .i_ra      (w_ra),
        .i_rb      (w_rb),
        .i_rc      (w_rc),
        .o_pend_ra (w_pend_ra),
        .o_pend_rb (w_pend_rb),
        .o_pend_rc (w_pend_rc)
    );

`ifdef ALU_ISSUE_FORWARD_EN
    // A pending source being written back this cycle is ready; take its value
    // from the writeback bus because the register file updates on this edge.
    assign w_fwd_ra = w_pend_ra & wb_valid & (wb_rc == w_ra);
    assign w_fwd_rb = w_pend_rb & wb_valid & (wb_rc == w_rb);
    assign w_ra_val = w_fwd_ra ? wb_data : ra_data;
    assign w_rb_val = w_fwd_rb ? wb_data : rb_data;
`else
    // No bypass: a pending source waits until the register file holds it.
    logic w_unused_wb;
    assign w_fwd_ra    = 1'b0;
    assign w_fwd_rb    = 1'b0;
    assign w_ra_val    = ra_data;
    assign w_rb_val    = rb_data;
    assign w_unused_wb = ^wb_data;
`endif

    // rb is a source only for register-register instructions; a pending
    // destination always stalls (write-after-write), bypass or not.
    assign w_hazard = (w_pend_ra & ~w_fwd_ra)
                    | ((w_class == CLASS_RR) & w_pend_rb & ~w_fwd_rb)
                    | w_pend_rc;

    // NOP and illegal are always consumable; issuing needs a free output slot
    assign in_ready = ~reset & ~flush
                    & (~w_class[1] | (~w_hazard & ((r_state == ST_EMPTY) | out_ready)));
    assign w_accept = in_valid & in_ready;
    assign w_issue  = w_accept & w_class[1];

    // Operand muxes; the zero register reads 0 regardless of read data
    assign w_a = (w_ra == L_ZERO) ? '0 : w_ra_val;
    assign w_b = (w_class == CLASS_RL) ? {{(XLEN-LIT_W){w_lit[LIT_W-1]}}, w_lit}
               : (w_rb == L_ZERO)      ? '0
               : w_rb_val;

    // Output register FSM: EMPTY/FULL occupancy plus the illegal pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_a       <= '0;
            r_b       <= '0;
            r_fn      <= '0;
            r_rc      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept & (w_class == CLASS_ILL);
            if (flush) begin
                r_state <= ST_EMPTY;
            end else if (w_issue) begin
                r_state <= ST_FULL;
                r_a     <= w_a;
                r_b     <= w_b;
                r_fn    <= w_fn;
                r_rc    <= w_rc;
            end else if ((r_state == ST_FULL) && out_ready) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_fn    = r_fn;
    assign out_rc    = r_rc;
    assign illegal   = r_illegal;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reset, register/literal issue, RAW/WAW
// hazards, backpressure, illegal pulse, flush and mid-operation reset.
// Honors ALU_ISSUE_FORWARD_EN for the RAW timing expectations.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [5:0]  out_fn;
    logic [4:0]  out_rc;
    logic        wb_valid;
    logic [4:0]  wb_rc;
    logic [31:0] wb_data;
    logic        flush;
    logic        illegal;
    logic        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Register-file model: combinational read, write on the writeback edge
    logic [31:0] rf [32];
    assign ra_data = rf[ra_addr];
    assign rb_data = rf[rb_addr];
    always @(posedge clk) if (wb_valid) rf[wb_rc] <= wb_data;

    alu_issue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .ra_data   (ra_data),
        .rb_data   (rb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_fn    (out_fn),
        .out_rc    (out_rc),
        .wb_valid  (wb_valid),
        .wb_rc     (wb_rc),
        .wb_data   (wb_data),
        .flush     (flush),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk_rr(input logic [5:0] fn, input logic [4:0] rc,
                                          input logic [4:0] ra, input logic [4:0] rb);
        return {2'b10, fn, rc, ra, rb, 9'd0};
    endfunction

    function automatic logic [31:0] mk_rl(input logic [5:0] fn, input logic [4:0] rc,
                                          input logic [4:0] ra, input logic [13:0] lit);
        return {2'b11, fn, rc, ra, lit};
    endfunction

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        wb_valid = 1'b0; wb_rc = '0; wb_data = '0;
        in_instr = mk_rr(FN_ADD, 5'd1, 5'd2, 5'd3);
        tick();
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_held: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal: got %b want 0", illegal); end
        n_cmp++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL rst_state: got %b want 0", dbg_state); end
        n_cmp++; if (out_a !== 32'd0 || out_b !== 32'd0) begin n_bad++; $display("FAIL rst_ab: got %h/%h want 0/0", out_a, out_b); end
        n_cmp++; if (out_fn !== 6'd0 || out_rc !== 5'd0) begin n_bad++; $display("FAIL rst_fn_rc: got %h/%h want 0/0", out_fn, out_rc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_rr_issue();
        in_valid = 1'b1;
        in_instr = mk_rr(FN_ADD, 5'd1, 5'd2, 5'd3);
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_a !== 32'd5) begin n_bad++; $display("FAIL rr_a: got %h want %h", out_a, 32'd5); end
        n_cmp++; if (out_b !== 32'd7) begin n_bad++; $display("FAIL rr_b: got %h want %h", out_b, 32'd7); end
        n_cmp++; if (out_fn !== 6'h10) begin n_bad++; $display("FAIL rr_fn: got %h want 10", out_fn); end
        n_cmp++; if (out_rc !== 5'd1) begin n_bad++; $display("FAIL rr_rc: got %0d want 1", out_rc); end
        in_instr = mk_rr(FN_SUB, 5'd5, 5'd31, 5'd2);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rr_b2b_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_a !== 32'd0) begin n_bad++; $display("FAIL rr_zero_a: got %h want 0", out_a); end
        n_cmp++; if (out_b !== 32'd5 || out_fn !== 6'h11 || out_rc !== 5'd5) begin n_bad++; $display("FAIL rr_second: got b=%h fn=%h rc=%0d want b=5 fn=11 rc=5", out_b, out_fn, out_rc); end
        in_instr = mk_rr(FN_ADD, 5'd31, 5'd3, 5'd31);
        tick();
        n_cmp++; if (out_a !== 32'd7 || out_b !== 32'd0) begin n_bad++; $display("FAIL rr_zero_b: got a=%h b=%h want a=7 b=0", out_a, out_b); end
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rc = 5'd1; wb_data = 32'h11;
        tick();
        wb_rc = 5'd5; wb_data = 32'h55;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_literal();
        in_valid = 1'b1;
        in_instr = mk_rl(FN_ADD, 5'd31, 5'd2, 14'h3FFF);
        tick();
        n_cmp++; if (out_b !== 32'hFFFFFFFF || out_a !== 32'd5) begin n_bad++; $display("FAIL lit_neg: got a=%h b=%h want a=5 b=ffffffff", out_a, out_b); end
        in_instr = mk_rl(FN_ADD, 5'd31, 5'd2, 14'h0005);
        tick();
        n_cmp++; if (out_b !== 32'd5) begin n_bad++; $display("FAIL lit_pos: got %h want 5", out_b); end
        in_instr = mk_rl(FN_ADD, 5'd31, 5'd2, 14'h1FFF);
        tick();
        n_cmp++; if (out_b !== 32'h00001FFF) begin n_bad++; $display("FAIL lit_maxpos: got %h want 00001fff", out_b); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_raw();
        in_valid = 1'b1;
        in_instr = mk_rr(FN_ADD, 5'd4, 5'd2, 5'd3);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_rc !== 5'd4) begin n_bad++; $display("FAIL raw_setup: got v=%b rc=%0d want v=1 rc=4", out_valid, out_rc); end
        in_instr = mk_rr(FN_ADD, 5'd6, 5'd4, 5'd3);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall1: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall2: got %b want 0", in_ready); end
        wb_valid = 1'b1; wb_rc = 5'd4; wb_data = 32'h1234;
        #1;
`ifdef ALU_ISSUE_FORWARD_EN
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_fwd_ready: got %b want 1", in_ready); end
        tick();
        wb_valid = 1'b0;
`else
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_wb_cycle: got %b want 0", in_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_after_wb: got %b want 1", in_ready); end
        tick();
`endif
        n_cmp++; if (out_a !== 32'h1234 || out_b !== 32'd7) begin n_bad++; $display("FAIL raw_operands: got a=%h b=%h want a=1234 b=7", out_a, out_b); end
        // r6 now pending: literal class ignores the rb field
        in_instr = mk_rl(FN_ADD, 5'd31, 5'd2, 14'h0C00);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rl_rb_not_src: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_b !== 32'h00000C00) begin n_bad++; $display("FAIL rl_b: got %h want 00000c00", out_b); end
        in_instr = mk_rr(FN_ADD, 5'd31, 5'd2, 5'd6);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rb_hazard: got %b want 0", in_ready); end
        in_instr = mk_rr(FN_ADD, 5'd6, 5'd2, 5'd3);
        wb_valid = 1'b1; wb_rc = 5'd6; wb_data = 32'h66;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL waw_wb_cycle: got %b want 0", in_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL waw_cleared: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_rc !== 5'd6) begin n_bad++; $display("FAIL waw_rc: got %0d want 6", out_rc); end
        // set and clear of r7 in the same cycle leaves it pending
        in_instr = mk_rr(FN_ADD, 5'd7, 5'd2, 5'd3);
        wb_valid = 1'b1; wb_rc = 5'd7; wb_data = 32'h77;
        tick();
        wb_valid = 1'b0;
        in_instr = mk_rr(FN_ADD, 5'd31, 5'd7, 5'd3);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL set_wins: got %b want 0", in_ready); end
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rc = 5'd7; wb_data = 32'h77;
        tick();
        wb_rc = 5'd6; wb_data = 32'h66;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = mk_rr(6'h25, 5'd31, 5'd2, 5'd3);
        tick();
        in_instr = mk_rr(6'h20, 5'd31, 5'd3, 5'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_%0d: got %b want 0", k, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'd5 || out_b !== 32'd7 || out_fn !== 6'h25 || out_rc !== 5'd31) begin
                n_bad++; $display("FAIL bp_hold_%0d: got v=%b a=%h b=%h fn=%h rc=%0d want v=1 a=5 b=7 fn=25 rc=31", k, out_valid, out_a, out_b, out_fn, out_rc);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_a !== 32'd7 || out_b !== 32'd5 || out_fn !== 6'h20) begin n_bad++; $display("FAIL bp_next: got a=%h b=%h fn=%h want a=7 b=5 fn=20", out_a, out_b, out_fn); end
        in_instr = mk_rl(6'h30, 5'd31, 5'd3, 14'd9);
        tick();
        n_cmp++; if (out_a !== 32'd7 || out_b !== 32'd9 || out_fn !== 6'h30) begin n_bad++; $display("FAIL bp_b2b: got a=%h b=%h fn=%h want a=7 b=9 fn=30", out_a, out_b, out_fn); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = mk_rr(6'h2A, 5'd31, 5'd3, 5'd2);
        tick();
        in_instr = {2'b01, 6'h10, 5'd4, 5'd4, 5'd4, 9'd0};
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %b want 1", in_ready); end
        tick();
        in_instr = 32'd0;
        n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_pulse: got %b want 1", illegal); end
        n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'd7) begin n_bad++; $display("FAIL ill_out_kept: got v=%b a=%h want v=1 a=7", out_valid, out_a); end
        tick();
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL ill_one_cycle: got %b want 0", illegal); end
        n_cmp++; if (out_valid !== 1'b1 || out_fn !== 6'h2A) begin n_bad++; $display("FAIL nop_no_issue: got v=%b fn=%h want v=1 fn=2a", out_valid, out_fn); end
        out_ready = 1'b1;
        in_instr = mk_rr(FN_ADD, 5'd4, 5'd2, 5'd3);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        flush = 1'b1;
        in_instr = mk_rr(FN_ADD, 5'd31, 5'd4, 5'd3);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty: got %b want 0", out_valid); end
        in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_sb_clear: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'h1234) begin n_bad++; $display("FAIL flush_reissue: got v=%b a=%h want v=1 a=1234", out_valid, out_a); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || out_a !== 32'd0 || out_rc !== 5'd0) begin n_bad++; $display("FAIL mid_reset: got v=%b a=%h rc=%0d want 0/0/0", out_valid, out_a, out_rc); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[2]  = 32'd5;
        rf[3]  = 32'd7;
        rf[31] = 32'hDEADBEEF;
        test_reset();
        test_rr_issue();
        test_literal();
        test_raw();
        test_backpressure();
        test_illegal_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
